// File: rtl/threshold_loader.sv
// threshold_loader: parses 5-byte command frames (HEADER, CMD, HI, LO, CHK)
// from the UART receiver and holds the 11-bit open/close thresholds used by the
// encoder-window comparator. Thresholds change only on a frame whose checksum
// matches. Malformed, stalled or bad-checksum frames pulse frame_err.
// Optional feature macro: THRESH_ACK_EN adds an ACK/NAK byte port towards the
// UART transmitter (tx_data/tx_valid/tx_ready).
module threshold_loader #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [10:0] OPEN_RST       = 11'd1500,
  parameter logic [10:0] CLOSE_RST      = 11'd500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [10:0] open,
  output logic [10:0] close,
  output logic        update,
  output logic        frame_err
`ifdef THRESH_ACK_EN
  ,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
`endif
);

  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [7:0]       CMD_OPEN  = 8'h01;
  localparam logic [7:0]       CMD_CLOSE = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_HI,
    S_LO,
    S_CHK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       hi_q, hi_d;
  logic [7:0]       lo_q, lo_d;
  logic [10:0]      open_q, open_d;
  logic [10:0]      close_q, close_d;
  logic             update_q, frame_err_q;
  logic             good;   // frame accepted this cycle
  logic             bad;    // frame rejected (format, checksum or timeout)

  // Next-state, field capture, threshold load and inter-byte timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    open_d  = open_q;
    close_d = close_q;
    good    = 1'b0;
    bad     = 1'b0;

    if (state_q == S_IDLE) begin
      // Counter parks at zero; non-header bytes are dropped without complaint.
      cnt_d = '0;
      if (rx_valid && (rx_data == HEADER)) begin
        state_d = S_CMD;
      end
    end else if (rx_valid) begin
      // A byte always beats a timeout landing in the same cycle.
      cnt_d = '0;
      case (state_q)
        S_CMD: begin
          if ((rx_data == CMD_OPEN) || (rx_data == CMD_CLOSE)) begin
            cmd_d   = rx_data;
            state_d = S_HI;
          end else begin
            bad     = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_HI: begin
          if (rx_data[7:3] != 5'd0) begin
            bad     = 1'b1;
            state_d = S_IDLE;
          end else begin
            hi_d    = rx_data;
            state_d = S_LO;
          end
        end
        S_LO: begin
          lo_d    = rx_data;
          state_d = S_CHK;
        end
        S_CHK: begin
          state_d = S_IDLE;
          if (rx_data == (cmd_q ^ hi_q ^ lo_q)) begin
            good = 1'b1;
            if (cmd_q == CMD_OPEN) begin
              open_d = {hi_q[2:0], lo_q};
            end else begin
              close_d = {hi_q[2:0], lo_q};
            end
          end else begin
            bad = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else if (cnt_q == CNT_LIMIT) begin
      // Stalled mid-frame: abandon it.
      bad     = 1'b1;
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Control state, thresholds and result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      open_q      <= OPEN_RST;
      close_q     <= CLOSE_RST;
      update_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      open_q      <= open_d;
      close_q     <= close_d;
      update_q    <= good;
      frame_err_q <= bad;
    end
  end

  // Frame field holding registers; always written before they are read.
  always_ff @(posedge clk) begin
    cmd_q <= cmd_d;
    hi_q  <= hi_d;
    lo_q  <= lo_d;
  end

  assign open      = open_q;
  assign close     = close_q;
  assign update    = update_q;
  assign frame_err = frame_err_q;

`ifdef THRESH_ACK_EN
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic [7:0] tx_data_q;
  logic       tx_valid_q;

  // Ack byte: a new result overwrites any pending one; handshake clears valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else if (good || bad) begin
      tx_data_q  <= good ? ACK : NAK;
      tx_valid_q <= 1'b1;
    end else if (tx_valid_q && tx_ready) begin
      tx_valid_q <= 1'b0;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
`endif

endmodule

// File: tb/tb_threshold_loader.sv
// Scoreboard bench for threshold_loader: stimulus pushes the expected result
// of each frame into a queue, a monitor pops and compares on every
// update/frame_err pulse (and on every ack transfer when THRESH_ACK_EN is set).
module tb_threshold_loader;

  localparam int TL = 40;   // shortened timeout for simulation

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [10:0] open_w, close_w;
  logic        update, frame_err;
`ifdef THRESH_ACK_EN
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    bit err;
    int op;
    int cl;
  } ev_t;

  ev_t exp_q[$];
  int  ack_q[$];

  always #5 clk = ~clk;

  threshold_loader #(
    .HEADER(8'hA5),
    .TIMEOUT_CYCLES(TL),
    .OPEN_RST(11'd1500),
    .CLOSE_RST(11'd500)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .open(open_w),
    .close(close_w),
    .update(update),
    .frame_err(frame_err)
`ifdef THRESH_ACK_EN
    ,
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input bit err, input int op, input int cl);
    ev_t e;
    e.err = err;
    e.op  = op;
    e.cl  = cl;
    exp_q.push_back(e);
    ack_q.push_back(err ? 8'h15 : 8'h06);
  endtask

  // Called on a falling edge; byte is taken on the next rising edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4);
    send(b0);
    send(b1);
    send(b2);
    send(b3);
    send(b4);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every result pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (update || frame_err) begin
        chk("update_and_err_exclusive", update & frame_err, 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_event: update=%0d frame_err=%0d open=%0d close=%0d, none expected",
                   update, frame_err, open_w, close_w);
        end else begin : pop_ev
          ev_t e;
          e = exp_q.pop_front();
          chk("frame_err_flag", frame_err, e.err);
          chk("open_value", open_w, e.op);
          chk("close_value", close_w, e.cl);
        end
      end
`ifdef THRESH_ACK_EN
      if (tx_valid && tx_ready) begin
        if (ack_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_ack: tx_data=%0h, none expected", tx_data);
        end else begin
          chk("tx_data", tx_data, ack_q.pop_front());
        end
      end
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values
    repeat (3) @(negedge clk);
    chk("rst_open", open_w, 1500);
    chk("rst_close", close_w, 500);
    chk("rst_update", update, 0);
    chk("rst_frame_err", frame_err, 0);
`ifdef THRESH_ACK_EN
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
`endif
    rst_n = 1'b1;
    idle(2);

    // 2: load open = {3'b011, 8'h20} = 800
    push(0, 800, 500);
    frame(8'hA5, 8'h01, 8'h03, 8'h20, 8'h22);
    idle(3);

    // 3: load close = 100, then bad checksum leaves it at 100
    push(0, 800, 100);
    frame(8'hA5, 8'h02, 8'h00, 8'h64, 8'h66);
    idle(2);
    push(1, 800, 100);
    frame(8'hA5, 8'h02, 8'h00, 8'h64, 8'h00);
    idle(3);

    // 4: bad CMD, bad HI (trailing bytes dropped in idle), then open = 5
    push(1, 800, 100);
    send(8'hA5); send(8'h03);
    idle(2);
    push(1, 800, 100);
    send(8'hA5); send(8'h01); send(8'h08); send(8'h00); send(8'h09);
    idle(2);
    push(0, 5, 100);
    frame(8'hA5, 8'h01, 8'h00, 8'h05, 8'h04);
    idle(3);

    // 5: timeout after TL silent clocks; bytes at TL-1 gaps are accepted
    push(1, 5, 100);
    send(8'hA5); send(8'h01);
    idle(TL);
    chk("timeout_err_at_limit", frame_err, 1);
    idle(3);
    push(0, 7, 100);
    send(8'hA5); send(8'h01);
    idle(TL - 1);
    send(8'h00);
    idle(TL - 1);
    send(8'h07);
    idle(TL - 1);
    send(8'h06);
    idle(3);

    // 6a: results while the transmitter is stalled; newest code kept
`ifdef THRESH_ACK_EN
    tx_ready = 1'b0;
`endif
    push(0, 9, 100);
    frame(8'hA5, 8'h01, 8'h00, 8'h09, 8'h08);
    idle(2);
    push(1, 9, 100);
    frame(8'hA5, 8'h01, 8'h00, 8'h09, 8'h00);
    idle(3);
`ifdef THRESH_ACK_EN
    chk("tx_valid_held", tx_valid, 1);
    chk("tx_data_last", tx_data, 8'h15);
    void'(ack_q.pop_front());   // ACK of the first frame was overwritten
    @(posedge clk);
    #1 tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("tx_valid_dropped", tx_valid, 0);
`endif

    // 6b: reset mid-frame discards the partial frame and restores thresholds
    send(8'hA5); send(8'h01); send(8'h03);
    rst_n = 1'b0;
    #1;
    chk("midrst_open", open_w, 1500);
    chk("midrst_close", close_w, 500);
    chk("midrst_update", update, 0);
    chk("midrst_frame_err", frame_err, 0);
`ifdef THRESH_ACK_EN
    chk("midrst_tx_valid", tx_valid, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h20); send(8'h22);   // would complete the old frame if state survived
    idle(2);
    push(0, 1500, 10);
    frame(8'hA5, 8'h02, 8'h00, 8'h0A, 8'h08);
    idle(4);

    chk("events_drained", exp_q.size(), 0);
`ifdef THRESH_ACK_EN
    chk("acks_drained", ack_q.size(), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
